// File: rtl/song_reader.sv
// Song sequencer: walks a song ROM, hands each note to the note player and its
// duration to an external beat timer, and honours play/pause from a level input.
module song_reader #(
  parameter int IDX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic [1:0]            song,
  input  logic                  beat,
  output logic [IDX_BITS+1:0]   rom_addr,
  input  logic [11:0]           rom_data,
  output logic                  beat_out,
  output logic [5:0]            duration_to_load,
  output logic                  timer_clear,
  input  logic                  timer_done,
  output logic [5:0]            note,
  output logic                  new_note,
  output logic                  song_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] PLAY   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  logic [2:0]          state;
  logic [IDX_BITS-1:0] idx;
  logic [1:0]          song_q;
  logic                play_q;
  logic [5:0]          rom_note;
  logic [5:0]          rom_dur;
  logic                note_expired;

  assign rom_addr = {song_q, idx};
  assign rom_note = rom_data[11:6];
  assign rom_dur  = rom_data[5:0];

  // Beats only reach the timer while a note is actually sounding.
  assign beat_out = (state == PLAY) & beat & play;

  // The clear pulse lands in the first PLAY cycle; a done seen then is stale.
  assign note_expired = play & timer_done & ~timer_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      song_q           <= 2'd0;
      play_q           <= 1'b1;
      note             <= 6'd0;
      duration_to_load <= 6'd0;
      new_note         <= 1'b0;
      timer_clear      <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      // play_q tracks play in every state so a held level never retriggers.
      play_q      <= play;
      new_note    <= 1'b0;
      timer_clear <= 1'b0;
      song_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (play && !play_q) begin
            song_q <= song;
            idx    <= '0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          state <= DECODE;
        end
        DECODE: begin
          if (rom_dur != 6'd0) begin
            note             <= rom_note;
            duration_to_load <= rom_dur;
            new_note         <= 1'b1;
            timer_clear      <= 1'b1;
            state            <= PLAY;
          end else begin
            state <= DONE;
          end
        end
        PLAY: begin
          if (note_expired) begin
            if (idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          song_done <= 1'b1;
          new_note  <= (note != 6'd0);
          note      <= 6'd0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a behavioural song ROM, beat generator
// and beat timer around the reader.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b1;
  logic [1:0]  song = 2'd1;
  logic        beat = 1'b0;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic        beat_out;
  logic [5:0]  duration_to_load;
  logic        timer_clear;
  logic        timer_done;
  logic [5:0]  note;
  logic        new_note;
  logic        song_done;

  int ncmp = 0;
  int nfail = 0;

  logic [11:0] rom [0:127];
  logic        beat_en = 1'b0;
  logic [1:0]  bph = 2'd0;
  logic [5:0]  tcnt = 6'd0;

  logic        mon_clr = 1'b1;
  int          cnt_nn = 0;
  int          cnt_sd = 0;
  int          cnt_bo = 0;
  int          cnt10 = 0;
  int          cnt20 = 0;
  logic [5:0]  last_note = 6'd0;
  int          bo_before;

  song_reader #(.IDX_BITS(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .beat             (beat),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .beat_out         (beat_out),
    .duration_to_load (duration_to_load),
    .timer_clear      (timer_clear),
    .timer_done       (timer_done),
    .note             (note),
    .new_note         (new_note),
    .song_done        (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (reset) bph <= 2'd0;
    else bph <= bph + 2'd1;
    beat <= beat_en && (bph == 2'd3);
  end

  // Beat timer: clear wins over a coincident beat.
  always @(posedge clk) begin
    if (reset) tcnt <= 6'd0;
    else if (timer_clear) tcnt <= duration_to_load;
    else if (beat_out && tcnt != 6'd0) tcnt <= tcnt - 6'd1;
  end
  assign timer_done = beat_out && (tcnt == 6'd1);

  always @(posedge clk) begin
    if (mon_clr) begin
      cnt_nn <= 0; cnt_sd <= 0; cnt_bo <= 0; cnt10 <= 0; cnt20 <= 0;
      last_note <= 6'd0;
    end else begin
      if (new_note) begin
        cnt_nn <= cnt_nn + 1;
        if (note != 6'd0) last_note <= note;
      end
      if (song_done) cnt_sd <= cnt_sd + 1;
      if (beat_out) cnt_bo <= cnt_bo + 1;
      if (beat_out && !timer_clear && note == 6'd10) cnt10 <= cnt10 + 1;
      if (beat_out && !timer_clear && note == 6'd20) cnt20 <= cnt20 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    ncmp++;
    nfail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic start_song(input logic [1:0] s);
    song = s;
    play = 1'b0;
    @(negedge clk);
    play = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (song_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout(tag);
  endtask

  task automatic wait_note(input logic [5:0] v, input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (note !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout(tag);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    rom[32] = {6'd10, 6'd2};
    rom[33] = {6'd20, 6'd3};
    rom[34] = 12'd0;
    rom[64] = {6'd30, 6'd1};
    rom[65] = 12'd0;
    for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'd1};

    // Reset with play held high throughout
    repeat (3) @(negedge clk);
    chk("rst_note", note, 6'd0);
    chk("rst_new_note", new_note, 1'b0);
    chk("rst_song_done", song_done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_timer_clear", timer_clear, 1'b0);
    chk("post_rst_beat_out", beat_out, 1'b0);
    chk("post_rst_rom_addr", rom_addr, 7'd0);
    chk("post_rst_duration", duration_to_load, 6'd0);
    mon_clr = 1'b0;
    beat_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("held_play_no_start", cnt_nn, 0);

    // Start latency and first note
    start_song(2'd1);
    @(negedge clk);
    chk("fetch_rom_addr", rom_addr, 7'd32);
    chk("fetch_new_note", new_note, 1'b0);
    @(negedge clk);
    chk("decode_new_note", new_note, 1'b0);
    chk("decode_beat_out", beat_out, 1'b0);
    @(negedge clk);
    chk("start_new_note", new_note, 1'b1);
    chk("start_timer_clear", timer_clear, 1'b1);
    chk("start_note", note, 6'd10);
    chk("start_duration", duration_to_load, 6'd2);
    @(negedge clk);
    chk("start_new_note_1cyc", new_note, 1'b0);
    chk("start_timer_clear_1cyc", timer_clear, 1'b0);

    // Sequencing through the rest of song 1
    wait_done("seq_done_wait", 200);
    chk("seq_done_note", note, 6'd0);
    chk("seq_done_new_note", new_note, 1'b1);
    chk("seq_beats_note10", cnt10, 2);
    chk("seq_beats_note20", cnt20, 3);
    @(negedge clk);
    chk("seq_song_done_1cyc", song_done, 1'b0);
    chk("seq_song_done_count", cnt_sd, 1);
    chk("seq_new_note_count", cnt_nn, 3);
    repeat (20) @(negedge clk);
    chk("no_auto_repeat", cnt_nn, 3);

    // Pause during note 20
    clear_mon();
    start_song(2'd1);
    wait_note(6'd20, "pause_wait_note20", 200);
    begin
      int n;
      n = 0;
      while (cnt20 < 1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) timeout("pause_wait_beat");
    end
    play = 1'b0;
    bo_before = cnt_bo;
    repeat (20) @(negedge clk);
    chk("pause_note_held", note, 6'd20);
    chk("pause_no_beat_out", cnt_bo, bo_before);
    chk("pause_beats_frozen", cnt20, 1);
    play = 1'b1;
    wait_done("pause_done_wait", 200);
    chk("pause_total_beats20", cnt20, 3);
    chk("pause_total_beats10", cnt10, 2);

    // Full 32-entry song
    clear_mon();
    start_song(2'd3);
    wait_done("full_done_wait", 1500);
    chk("full_idx_no_wrap", rom_addr, 7'd127);
    chk("full_done_new_note", new_note, 1'b1);
    repeat (20) @(negedge clk);
    chk("full_new_note_count", cnt_nn, 33);
    chk("full_song_done_count", cnt_sd, 1);
    chk("full_last_note", last_note, 6'd32);
    chk("full_note_silent", note, 6'd0);
    chk("full_rom_addr_held", rom_addr, 7'd127);

    // Reset mid-song with play held, then retrigger
    clear_mon();
    start_song(2'd1);
    wait_note(6'd20, "rst_wait_note20", 200);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_note", note, 6'd0);
    chk("abort_song_done", song_done, 1'b0);
    chk("abort_new_note", new_note, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_song_done", cnt_sd, 0);
    chk("abort_no_restart", cnt_nn, 2);
    chk("abort_note_silent", note, 6'd0);
    start_song(2'd1);
    repeat (3) @(negedge clk);
    chk("retrig_new_note", new_note, 1'b1);
    chk("retrig_note", note, 6'd10);
    chk("retrig_idx0", rom_addr, 7'd32);
    wait_done("retrig_done_wait", 200);

    // Song select latched at start
    clear_mon();
    start_song(2'd1);
    wait_note(6'd10, "latch_wait_note10", 200);
    song = 2'd2;
    wait_note(6'd20, "latch_wait_note20", 200);
    chk("latch_rom_song_mid", rom_addr >> 5, 7'd1);
    wait_done("latch_done_wait", 200);
    chk("latch_beats_note20", cnt20, 3);
    chk("latch_rom_song_end", rom_addr >> 5, 7'd1);
    start_song(2'd2);
    repeat (3) @(negedge clk);
    chk("song2_note", note, 6'd30);
    chk("song2_rom_addr", rom_addr, 7'd64);
    wait_done("song2_done_wait", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
